// File: rtl/keypad_time_entry_pkg.sv
// Shared key codes, FSM encoding and entry bundle for the keypad time entry path.
package keypad_time_entry_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      LOAD  = 2'd2
   } state_t;

   typedef struct packed {
      logic [3:0] ms_hr;
      logic [3:0] ls_hr;
      logic [3:0] ms_min;
      logic [3:0] ls_min;
   } entry_t;

   localparam logic [3:0] KEY_ALARM = 4'hA;
   localparam logic [3:0] KEY_TIME  = 4'hB;
   localparam logic [3:0] KEY_CLEAR = 4'hC;

   localparam int TIMEOUT_CYCLES_DEF = 2560;
   localparam int DIG_CNT_W          = 3;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

endpackage

// File: rtl/keypad_time_entry_bcd_time_check.sv
// Combinational HH:MM check of a 4-digit BCD entry.
module bcd_time_check
   import keypad_time_entry_pkg::*;
(
   input  logic [3:0]           ms_hr,
   input  logic [3:0]           ls_hr,
   input  logic [3:0]           ms_min,
   input  logic [3:0]           ls_min,
   input  logic [DIG_CNT_W-1:0] count,
   output logic                 valid
);

   logic [3:0] hr_lim;

   // 20..23 is the only decade where the units digit is limited
   assign hr_lim = (ms_hr == 4'd2) ? 4'd3 : 4'd9;

   assign valid = (count == DIG_CNT_W'(4))
                & (ms_hr  <= 4'd2)
                & (ls_hr  <= hr_lim)
                & (ms_min <= 4'd5)
                & (ls_min <= 4'd9);

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad to HH:MM entry: edge detect, shift-in digits, load/error strobes, idle timeout.
module keypad_time_entry
   import keypad_time_entry_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int CNT_W          = 12
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       key_valid,
   input  logic [3:0] key,
   output logic [3:0] key_ms_hr,
   output logic [3:0] key_ls_hr,
   output logic [3:0] key_ms_min,
   output logic [3:0] key_ls_min,
   output logic       show_new_time,
   output logic       load_new_alarm,
   output logic       load_new_time,
   output logic       entry_error
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t               state;
   entry_t               ent;
   entry_t               shifted;
   logic [DIG_CNT_W-1:0] count;
   logic [DIG_CNT_W-1:0] count_inc;
   logic [CNT_W-1:0]     tcnt;
   logic                 key_valid_q;
   logic                 press;
   logic                 is_dig;
   logic                 is_load;
   logic                 valid;

   assign press     = key_valid & ~key_valid_q;
   assign is_dig    = is_digit(key);
   assign is_load   = (key == KEY_ALARM) | (key == KEY_TIME);
   assign shifted   = {ent.ls_hr, ent.ms_min, ent.ls_min, key};
   assign count_inc = (count == DIG_CNT_W'(4)) ? count : count + 1'b1;

   assign key_ms_hr  = ent.ms_hr;
   assign key_ls_hr  = ent.ls_hr;
   assign key_ms_min = ent.ms_min;
   assign key_ls_min = ent.ls_min;

   bcd_time_check u_chk (
      .ms_hr  (ent.ms_hr),
      .ls_hr  (ent.ls_hr),
      .ms_min (ent.ms_min),
      .ls_min (ent.ls_min),
      .count  (count),
      .valid  (valid)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         ent            <= '0;
         count          <= '0;
         tcnt           <= '0;
         key_valid_q    <= 1'b0;
         show_new_time  <= 1'b0;
         load_new_alarm <= 1'b0;
         load_new_time  <= 1'b0;
         entry_error    <= 1'b0;
      end else begin
         key_valid_q    <= key_valid;
         load_new_alarm <= 1'b0;
         load_new_time  <= 1'b0;
         entry_error    <= 1'b0;
         unique case (state)
            IDLE: begin
               tcnt <= '0;
               if (press && is_dig) begin
                  ent           <= shifted;
                  count         <= count_inc;
                  state         <= ENTRY;
                  show_new_time <= 1'b1;
               end else if (press && is_load) begin
                  entry_error <= 1'b1;
               end
            end
            ENTRY: begin
               // a press always beats a timeout landing on the same edge
               if (press && is_dig) begin
                  ent   <= shifted;
                  count <= count_inc;
                  tcnt  <= '0;
               end else if (press && is_load && valid) begin
                  load_new_alarm <= (key == KEY_ALARM);
                  load_new_time  <= (key == KEY_TIME);
                  tcnt           <= '0;
                  state          <= LOAD;
               end else if (press && (is_load || key == KEY_CLEAR)) begin
                  entry_error   <= is_load;
                  ent           <= '0;
                  count         <= '0;
                  tcnt          <= '0;
                  state         <= IDLE;
                  show_new_time <= 1'b0;
               end else if (tcnt == TMO_LAST) begin
                  ent           <= '0;
                  count         <= '0;
                  tcnt          <= '0;
                  state         <= IDLE;
                  show_new_time <= 1'b0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            LOAD: begin
               ent           <= '0;
               count         <= '0;
               tcnt          <= '0;
               state         <= IDLE;
               show_new_time <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_time_entry.sv
// Scoreboard bench for keypad_time_entry: digit-list reference model, strobe monitor.
module tb_keypad_time_entry;

   localparam int T = 2560;

   typedef struct {
      int         kind;
      logic [15:0] d;
   } ev_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key = 4'h0;
   logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
   logic       show_new_time, load_new_alarm, load_new_time, entry_error;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   ev_t  sb[$];
   int   dq[$];
   bit   in_ent = 0;
   int   last = 0;

   keypad_time_entry dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .key_valid      (key_valid),
      .key            (key),
      .key_ms_hr      (key_ms_hr),
      .key_ls_hr      (key_ls_hr),
      .key_ms_min     (key_ms_min),
      .key_ls_min     (key_ls_min),
      .show_new_time  (show_new_time),
      .load_new_alarm (load_new_alarm),
      .load_new_time  (load_new_time),
      .entry_error    (entry_error)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [15:0] disp();
      return {key_ms_hr, key_ls_hr, key_ms_min, key_ls_min};
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, got, exp);
      end
   endtask

   // reference model: the entry is simply the list of digits typed so far
   function automatic logic [15:0] m_disp();
      logic [15:0] r = '0;
      int n = dq.size();
      for (int i = 0; i < 4; i++) begin
         int idx = n - 4 + i;
         r = {r[11:0], (idx >= 0) ? 4'(dq[idx]) : 4'h0};
      end
      return r;
   endfunction

   function automatic bit m_valid();
      int n = dq.size();
      int hh, mm;
      if (n < 4) return 0;
      hh = dq[n-4] * 10 + dq[n-3];
      mm = dq[n-2] * 10 + dq[n-1];
      return (hh < 24) && (mm < 60);
   endfunction

   task automatic m_clear();
      dq.delete();
      in_ent = 0;
   endtask

   task automatic m_expire(input int now, input bit strict);
      if (in_ent && (strict ? (now - last > T) : (now - last >= T)))
         m_clear();
   endtask

   task automatic chk_now(input string name);
      m_expire(cyc, 0);
      chk(name, {show_new_time, disp()}, {in_ent, m_disp()});
   endtask

   task automatic wait_to(input int edge_n);
      while (cyc < edge_n - 1) @(negedge clock);
   endtask

   // called right after a negedge; the press lands on the next posedge
   task automatic press(input logic [3:0] k, input int hold, input int gap);
      int e = cyc + 1;
      logic [15:0] xd;
      bit xs;
      if (k <= 4'd9) begin
         m_expire(e, 1);
         dq.push_back(int'(k));
         in_ent = 1;
         last = e;
         xd = m_disp();
         xs = 1;
      end else if (k == 4'hA || k == 4'hB) begin
         m_expire(e, 1);
         if (in_ent && m_valid()) begin
            sb.push_back(ev_t'{kind: (k == 4'hB) ? 1 : 0, d: m_disp()});
            xd = m_disp();
            xs = 1;
         end else begin
            sb.push_back(ev_t'{kind: 2, d: 16'h0});
            xd = '0;
            xs = 0;
         end
         m_clear();
      end else if (k == 4'hC) begin
         m_clear();
         xd = '0;
         xs = 0;
      end else begin
         m_expire(e, 0);
         xd = m_disp();
         xs = in_ent;
      end
      key = k;
      key_valid = 1'b1;
      @(negedge clock);
      chk("disp_after_press", {show_new_time, disp()}, {xs, xd});
      for (int i = 1; i < hold; i++) @(negedge clock);
      key_valid = 1'b0;
      repeat (gap) @(negedge clock);
      chk_now("disp_settled");
   endtask

   task automatic press_hhmm(input int hh, input int mm, input logic [3:0] k);
      press(4'(hh / 10), 1, 1);
      press(4'(hh % 10), 2, 1);
      press(4'(mm / 10), 1, 2);
      press(4'(mm % 10), 3, 1);
      press(k, 2, 1);
   endtask

   // monitor: every strobe cycle must match the oldest expected event
   always @(negedge clock) begin
      int ns;
      ev_t ev;
      int kind;
      ns = int'(load_new_alarm) + int'(load_new_time) + int'(entry_error);
      if (ns > 0) begin
         kind = load_new_alarm ? 0 : (load_new_time ? 1 : 2);
         if (ns > 1) begin
            tests++;
            fails++;
            $display("FAIL strobe_onehot: got %0d strobes, required 1", ns);
         end else if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe @cyc %0d: got kind %0d, required none",
                     cyc, kind);
         end else begin
            ev = sb.pop_front();
            chk("strobe_kind", 32'(kind), 32'(ev.kind));
            chk("strobe_digits", {16'h0, disp()}, {16'h0, ev.d});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, required finish by 2 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("reset_outputs",
          {show_new_time, load_new_alarm, load_new_time, entry_error, disp()},
          32'h0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // 1: alarm load
      press(4'd1, 5, 2);
      press(4'd2, 5, 2);
      press(4'd3, 5, 2);
      press(4'd4, 5, 2);
      press(4'hA, 5, 2);

      // 2: invalid 24:00, then valid 23:59
      press_hhmm(24, 0, 4'hB);
      press_hhmm(23, 59, 4'hB);

      // 3: five digits keep the last four; short entry errors
      press(4'd1, 1, 1);
      press(4'd2, 1, 1);
      press(4'd3, 1, 1);
      press(4'd4, 1, 1);
      press(4'd5, 1, 1);
      chk("five_digits", {16'h0, disp()}, 32'h2345);
      press(4'hB, 1, 2);
      press(4'd0, 1, 1);
      press(4'd7, 1, 1);
      press(4'hA, 1, 2);

      // 4: timeout boundary, press on the expiry edge wins
      press(4'd9, 1, 1);
      wait_to(last + T - 1);
      chk_now("pre_timeout");
      chk("pre_timeout_show", {31'h0, show_new_time}, 32'h1);
      wait_to(last + T);
      press(4'd5, 1, 1);
      chk("expiry_press_kept", {16'h0, disp()}, 32'h0095);
      wait_to(last + T);
      chk_now("timeout_minus1");
      @(negedge clock);
      chk_now("timeout_cleared");
      chk("timeout_show", {31'h0, show_new_time}, 32'h0);

      // 5: long hold, ignored key, clear, load from idle
      press(4'd5, 100, 2);
      chk("long_hold", {16'h0, disp()}, 32'h0005);
      press(4'd3, 1, 1);
      wait_to(last + T / 2);
      press(4'hE, 1, 1);
      chk("ignored_key", {16'h0, disp()}, 32'h0053);
      wait_to(last + T);
      chk_now("e_no_restart_pre");
      @(negedge clock);
      chk_now("e_no_restart");
      press(4'd4, 1, 1);
      press(4'hC, 1, 1);
      press(4'hA, 1, 1);

      // 6: async reset during LOAD
      press_hhmm(12, 34, 4'hD);
      key = 4'hA;
      key_valid = 1'b1;
      @(posedge clock);
      #1;
      chk("load_before_reset", {31'h0, load_new_alarm}, 32'h1);
      #1 reset_n = 1'b0;
      #1;
      chk("reset_in_load",
          {show_new_time, load_new_alarm, load_new_time, entry_error, disp()},
          32'h0);
      key_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      m_clear();
      @(negedge clock);
      @(negedge clock);
      chk_now("after_reset");

      // random traffic against the model
      for (int it = 0; it < 250; it++) begin
         int r = $urandom_range(0, 99);
         if (r < 8) begin
            press_hhmm($urandom_range(0, 23), $urandom_range(0, 59),
                       ($urandom_range(0, 1) == 1) ? 4'hB : 4'hA);
         end else if (r < 11) begin
            repeat ($urandom_range(T - 3, T + 3)) @(negedge clock);
            chk_now("rand_idle");
         end else begin
            logic [3:0] k;
            k = (r < 70) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            press(k, $urandom_range(1, 4), $urandom_range(1, 4));
         end
      end

      repeat (4) @(negedge clock);
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
